// File: rtl/rmt_deparse_pkg.sv
// Shared deparse/parse constants: action field layout, container type encodings and widths.
// Used by both the field parser and the deparser so the two sides agree on action encoding.
package rmt_deparse_pkg;

    localparam int ACT_W        = 24;
    localparam int NUM_CONT     = 8;
    localparam int CONT_IDX_W   = 3;
    localparam int CONT_W_2B    = 16;
    localparam int CONT_W_4B    = 32;
    localparam int CONT_W_6B    = 48;

    localparam int ACT_VLD_BIT  = 0;
    localparam int ACT_IDX_LSB  = 1;
    localparam int ACT_TYPE_LSB = 7;
    localparam int ACT_TYPE_W   = 2;
    localparam int ACT_OFF_LSB  = 9;
    localparam int ACT_OFF_W    = 9;

    // 14 bits holds offset*8 + 48 for any 9-bit byte offset without wrapping.
    localparam int BIT_POS_W    = 14;

    typedef enum logic [ACT_TYPE_W-1:0] {
        TYPE_NONE = 2'b00,
        TYPE_2B   = 2'b01,
        TYPE_4B   = 2'b10,
        TYPE_6B   = 2'b11
    } cont_type_e;

    typedef struct packed {
        logic [ACT_W-ACT_OFF_LSB-ACT_OFF_W-1:0]          rsvd_hi;
        logic [ACT_OFF_W-1:0]                            off;
        cont_type_e                                      typ;
        logic [ACT_TYPE_LSB-ACT_IDX_LSB-CONT_IDX_W-1:0]  rsvd_lo;
        logic [CONT_IDX_W-1:0]                           idx;
        logic                                            vld;
    } act_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_OUTPUT = 2'd2
    } dep_state_e;

    function automatic logic [BIT_POS_W-1:0] type_width(input cont_type_e t);
        logic [BIT_POS_W-1:0] w;
        case (t)
            TYPE_2B: w = BIT_POS_W'(CONT_W_2B);
            TYPE_4B: w = BIT_POS_W'(CONT_W_4B);
            TYPE_6B: w = BIT_POS_W'(CONT_W_6B);
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic act_t decode_act(input logic [ACT_W-1:0] raw);
        return act_t'(raw);
    endfunction

endpackage

// File: rtl/deparse_field_writer.sv
// Applies one deparse action to a header: writes the selected container at its byte offset.
// Purely combinational; out-of-range writes are dropped and flagged through overflow.
module deparse_field_writer
    import rmt_deparse_pkg::*;
#(
    parameter int HDR_LEN = 4096
) (
    input  logic [HDR_LEN-1:0]              hdr_cur,
    input  logic [ACT_W-1:0]                act_raw,
    input  logic [NUM_CONT*CONT_W_2B-1:0]   phv_2b,
    input  logic [NUM_CONT*CONT_W_4B-1:0]   phv_4b,
    input  logic [NUM_CONT*CONT_W_6B-1:0]   phv_6b,
    output logic [HDR_LEN-1:0]              hdr_next,
    output logic                            overflow
);

    localparam logic [BIT_POS_W-1:0] HDR_BITS = BIT_POS_W'(HDR_LEN);

    act_t                   act;
    logic [CONT_W_6B-1:0]   field_dat;
    logic [CONT_W_6B-1:0]   field_mask;
    logic [BIT_POS_W-1:0]   bit_lo;
    logic [BIT_POS_W-1:0]   bit_end;
    logic                   active;
    logic                   fits;
    logic [HDR_LEN-1:0]     dat_shift;
    logic [HDR_LEN-1:0]     mask_shift;

    assign act = decode_act(act_raw);

    always_comb begin
        field_dat  = '0;
        field_mask = '0;
        case (act.typ)
            TYPE_2B: begin
                field_dat  = CONT_W_6B'(phv_2b[act.idx*CONT_W_2B +: CONT_W_2B]);
                field_mask = CONT_W_6B'({CONT_W_2B{1'b1}});
            end
            TYPE_4B: begin
                field_dat  = CONT_W_6B'(phv_4b[act.idx*CONT_W_4B +: CONT_W_4B]);
                field_mask = CONT_W_6B'({CONT_W_4B{1'b1}});
            end
            TYPE_6B: begin
                field_dat  = phv_6b[act.idx*CONT_W_6B +: CONT_W_6B];
                field_mask = {CONT_W_6B{1'b1}};
            end
            default: begin
                field_dat  = '0;
                field_mask = '0;
            end
        endcase
    end

    assign bit_lo   = BIT_POS_W'({act.off, 3'b000});
    assign bit_end  = bit_lo + type_width(act.typ);
    assign active   = act.vld && (act.typ != TYPE_NONE);
    assign fits     = (bit_end <= HDR_BITS);
    assign overflow = active && !fits;

    // Mask-and-merge rather than a variable part-select keeps the shifter a single barrel.
    assign dat_shift  = HDR_LEN'(field_dat)  << bit_lo;
    assign mask_shift = HDR_LEN'(field_mask) << bit_lo;

    assign hdr_next = (active && fits) ? ((hdr_cur & ~mask_shift) | dat_shift) : hdr_cur;

endmodule

// File: rtl/sub_deparser.sv
// Deparser: writes PHV containers back into the packet header, one action per cycle.
// Latency NUM_ACT+1 cycles accept-to-out_valid; out_ready low holds the result and blocks new input.
module sub_deparser
    import rmt_deparse_pkg::*;
#(
    parameter int PKTS_HDR_LEN = 4096,
    parameter int ACT_LEN      = ACT_W,
    parameter int NUM_ACT      = 10,
    parameter int C2_W         = CONT_W_2B,
    parameter int C4_W         = CONT_W_4B,
    parameter int C6_W         = CONT_W_6B
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PKTS_HDR_LEN-1:0]     pkts_hdr_in,
    input  logic [NUM_CONT*C2_W-1:0]    phv_2b,
    input  logic [NUM_CONT*C4_W-1:0]    phv_4b,
    input  logic [NUM_CONT*C6_W-1:0]    phv_6b,
    input  logic [NUM_ACT*ACT_LEN-1:0]  deparse_acts,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PKTS_HDR_LEN-1:0]     pkts_hdr_out,
    output logic                        out_err
);

    localparam int CNT_W = (NUM_ACT > 1) ? $clog2(NUM_ACT) : 1;
    localparam logic [CNT_W-1:0] LAST_ACT = CNT_W'(NUM_ACT - 1);

    dep_state_e                 state;
    logic [CNT_W-1:0]           act_cnt;
    logic [PKTS_HDR_LEN-1:0]    hdr_q;
    logic [PKTS_HDR_LEN-1:0]    hdr_nxt;
    logic [NUM_CONT*C2_W-1:0]   phv_2b_q;
    logic [NUM_CONT*C4_W-1:0]   phv_4b_q;
    logic [NUM_CONT*C6_W-1:0]   phv_6b_q;
    logic [NUM_ACT*ACT_LEN-1:0] acts_q;
    logic [ACT_LEN-1:0]         act_cur;
    logic                       err_q;
    logic                       wr_ovf;

    assign act_cur = acts_q[act_cnt*ACT_LEN +: ACT_LEN];

    deparse_field_writer #(
        .HDR_LEN    (PKTS_HDR_LEN)
    ) u_writer (
        .hdr_cur    (hdr_q),
        .act_raw    (act_cur),
        .phv_2b     (phv_2b_q),
        .phv_4b     (phv_4b_q),
        .phv_6b     (phv_6b_q),
        .hdr_next   (hdr_nxt),
        .overflow   (wr_ovf)
    );

    // The working header register doubles as the output register; it is only
    // presented as valid once every action has been applied.
    assign pkts_hdr_out = hdr_q;
    assign out_err      = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            act_cnt   <= '0;
            hdr_q     <= '0;
            phv_2b_q  <= '0;
            phv_4b_q  <= '0;
            phv_6b_q  <= '0;
            acts_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        hdr_q    <= pkts_hdr_in;
                        phv_2b_q <= phv_2b;
                        phv_4b_q <= phv_4b;
                        phv_6b_q <= phv_6b;
                        acts_q   <= deparse_acts;
                        err_q    <= 1'b0;
                        act_cnt  <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    hdr_q <= hdr_nxt;
                    if (wr_ovf) begin
                        err_q <= 1'b1;
                    end
                    if (act_cnt == LAST_ACT) begin
                        act_cnt   <= '0;
                        out_valid <= 1'b1;
                        state     <= ST_OUTPUT;
                    end else begin
                        act_cnt <= act_cnt + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_deparser.sv
// Randomized bench for sub_deparser against a byte-array reference model.
module tb_sub_deparser;

    localparam int HL = 4096;
    localparam int AL = 24;
    localparam int NA = 10;
    localparam int LAT = NA + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [HL-1:0]     pkts_hdr_in;
    logic [8*16-1:0]   phv_2b;
    logic [8*32-1:0]   phv_4b;
    logic [8*48-1:0]   phv_6b;
    logic [NA*AL-1:0]  deparse_acts;
    logic              out_valid;
    logic              out_ready;
    logic [HL-1:0]     pkts_hdr_out;
    logic              out_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sub_deparser dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pkts_hdr_in  (pkts_hdr_in),
        .phv_2b       (phv_2b),
        .phv_4b       (phv_4b),
        .phv_6b       (phv_6b),
        .deparse_acts (deparse_acts),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pkts_hdr_out (pkts_hdr_out),
        .out_err      (out_err)
    );

    task automatic chk(input string tag, input logic [HL-1:0] got, input logic [HL-1:0] exp);
        int w;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            w = 0;
            for (int i = HL/64 - 1; i >= 0; i--)
                if (got[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
            $display("FAIL %s: got %h expected %h (64-bit word %0d)",
                     tag, got[w*64 +: 64], exp[w*64 +: 64], w);
        end
    endtask

    function automatic logic [AL-1:0] mk_act(input int vld, input int typ, input int idx,
                                            input int off, input logic [31:0] junk);
        logic [AL-1:0] a;
        a = {junk[5:0], 9'(off), 2'(typ), junk[8:6], 3'(idx), 1'(vld)};
        return a;
    endfunction

    // Reference: header as a byte array, each action copies container bytes LSB-first.
    task automatic model(input logic [HL-1:0] hdr, input logic [NA*AL-1:0] acts,
                         input logic [8*16-1:0] p2, input logic [8*32-1:0] p4,
                         input logic [8*48-1:0] p6,
                         output logic [HL-1:0] o, output logic err);
        logic [7:0]    bytes [HL/8];
        logic [AL-1:0] a;
        logic [47:0]   val;
        int            nb, off, idx, typ;
        for (int b = 0; b < HL/8; b++) bytes[b] = hdr[b*8 +: 8];
        err = 1'b0;
        for (int k = 0; k < NA; k++) begin
            a   = acts[k*AL +: AL];
            typ = int'(a[8:7]);
            idx = int'(a[3:1]);
            off = int'(a[17:9]);
            nb  = (typ == 1) ? 2 : (typ == 2) ? 4 : (typ == 3) ? 6 : 0;
            if (typ == 1)      val = 48'(p2[idx*16 +: 16]);
            else if (typ == 2) val = 48'(p4[idx*32 +: 32]);
            else               val = p6[idx*48 +: 48];
            if (a[0] && nb != 0) begin
                if (off + nb > HL/8) err = 1'b1;
                else for (int j = 0; j < nb; j++) bytes[off + j] = val[j*8 +: 8];
            end
        end
        for (int b = 0; b < HL/8; b++) o[b*8 +: 8] = bytes[b];
    endtask

    task automatic rand_pkt(output logic [HL-1:0] hdr, output logic [NA*AL-1:0] acts,
                            output logic [8*16-1:0] p2, output logic [8*32-1:0] p4,
                            output logic [8*48-1:0] p6);
        int off;
        for (int i = 0; i < HL/32; i++) hdr[i*32 +: 32] = $urandom;
        for (int i = 0; i < 4; i++)  p2[i*32 +: 32] = $urandom;
        for (int i = 0; i < 8; i++)  p4[i*32 +: 32] = $urandom;
        for (int i = 0; i < 12; i++) p6[i*32 +: 32] = $urandom;
        for (int k = 0; k < NA; k++) begin
            off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(500, 511))
                                              : int'($urandom_range(0, 511));
            acts[k*AL +: AL] = mk_act(($urandom_range(0, 3) != 0) ? 1 : 0,
                                      int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                                      off, $urandom);
        end
    endtask

    task automatic run_pkt(input string tag, input logic [HL-1:0] hdr,
                           input logic [NA*AL-1:0] acts, input logic [8*16-1:0] p2,
                           input logic [8*32-1:0] p4, input logic [8*48-1:0] p6,
                           input int hold);
        logic [HL-1:0] eh;
        logic          eerr;
        int            lat;
        bit            stable;
        model(hdr, acts, p2, p4, p6, eh, eerr);
        @(negedge clk);
        out_ready = (hold == 0);
        chk({tag, " in_ready idle"}, HL'(in_ready), HL'(1));
        pkts_hdr_in  = hdr;
        deparse_acts = acts;
        phv_2b = p2; phv_4b = p4; phv_6b = p6;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, HL'(lat), HL'(LAT));
        chk({tag, " hdr"}, pkts_hdr_out, eh);
        chk({tag, " err"}, HL'(out_err), HL'(eerr));
        chk({tag, " in_ready busy"}, HL'(in_ready), HL'(0));
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (pkts_hdr_out !== eh || out_err !== eerr || out_valid !== 1'b1
                    || in_ready !== 1'b0) stable = 1'b0;
            end
            chk({tag, " held stable"}, HL'(stable), HL'(1));
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, " out_valid drop"}, HL'(out_valid), HL'(0));
        chk({tag, " in_ready back"}, HL'(in_ready), HL'(1));
    endtask

    logic [HL-1:0]    h;
    logic [NA*AL-1:0] acts;
    logic [8*16-1:0]  p2;
    logic [8*32-1:0]  p4;
    logic [8*48-1:0]  p6;
    logic [HL-1:0]    bh [4];
    logic [NA*AL-1:0] ba [4];
    logic [8*16-1:0]  b2 [4];
    logic [8*32-1:0]  b4 [4];
    logic [8*48-1:0]  b6 [4];
    logic [HL-1:0]    eq_h [$];
    logic             eq_e [$];

    initial begin
        logic [HL-1:0] eh;
        logic          ee;
        int            sent, got, t, last_t;
        bit            adv;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        pkts_hdr_in = '0; deparse_acts = '0; phv_2b = '0; phv_4b = '0; phv_6b = '0;
        repeat (3) @(negedge clk);
        chk("reset in_ready", HL'(in_ready), HL'(1));
        chk("reset out_valid", HL'(out_valid), HL'(0));
        chk("reset hdr", pkts_hdr_out, HL'(0));
        chk("reset err", HL'(out_err), HL'(0));
        rst = 1'b0;

        // Single 2B write into a zero header.
        h = '0; acts = '0; p2 = '0; p4 = '0; p6 = '0;
        p2[2*16 +: 16] = 16'hBEEF;
        acts[0 +: AL] = mk_act(1, 1, 2, 14, 32'h0);
        run_pkt("single2b", h, acts, p2, p4, p6, 0);

        // Overlap: later 2B write lands inside earlier 6B write.
        h = '0; acts = '0;
        p6[0 +: 48] = 48'h112233445566;
        p2[1*16 +: 16] = 16'hAAAA;
        acts[0*AL +: AL] = mk_act(1, 3, 0, 0, 32'h0);
        acts[1*AL +: AL] = mk_act(1, 1, 1, 2, 32'h0);
        run_pkt("overlap", h, acts, p2, p4, p6, 0);

        // Out of range 6B at offset 508, then legal writes touching the last byte.
        rand_pkt(h, acts, p2, p4, p6);
        acts = '0;
        acts[0 +: AL] = mk_act(1, 3, 5, 508, $urandom);
        run_pkt("oor6b", h, acts, p2, p4, p6, 0);
        acts = '0;
        acts[0*AL +: AL] = mk_act(1, 1, 7, 510, $urandom);
        acts[3*AL +: AL] = mk_act(1, 2, 3, 506, $urandom);
        acts[9*AL +: AL] = mk_act(0, 3, 1, 511, $urandom);
        run_pkt("edge_legal", h, acts, p2, p4, p6, 0);
        acts[5*AL +: AL] = mk_act(1, 2, 4, 509, $urandom);
        run_pkt("oor4b", h, acts, p2, p4, p6, 0);

        // Backpressure for 5 cycles.
        rand_pkt(h, acts, p2, p4, p6);
        run_pkt("bp5", h, acts, p2, p4, p6, 5);

        // Reset in the middle of WRITE.
        rand_pkt(h, acts, p2, p4, p6);
        @(negedge clk);
        pkts_hdr_in = h; deparse_acts = acts; phv_2b = p2; phv_4b = p4; phv_6b = p6;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst out_valid", HL'(out_valid), HL'(0));
        chk("midrst in_ready", HL'(in_ready), HL'(1));
        chk("midrst hdr", pkts_hdr_out, HL'(0));
        chk("midrst err", HL'(out_err), HL'(0));
        rand_pkt(h, acts, p2, p4, p6);
        run_pkt("after_rst", h, acts, p2, p4, p6, 0);

        // Back-to-back with in_valid held high.
        for (int i = 0; i < 4; i++) begin
            rand_pkt(h, acts, p2, p4, p6);
            bh[i] = h; ba[i] = acts; b2[i] = p2; b4[i] = p4; b6[i] = p6;
        end
        out_ready = 1'b1;
        sent = 0; got = 0; t = 0; last_t = -1; adv = 1'b0;
        @(negedge clk);
        pkts_hdr_in = bh[0]; deparse_acts = ba[0];
        phv_2b = b2[0]; phv_4b = b4[0]; phv_6b = b6[0];
        in_valid = 1'b1;
        while (got < 4 && t < 200) begin
            if (out_valid) begin
                chk("b2b expected", HL'(eq_h.size() != 0), HL'(1));
                if (eq_h.size() != 0) begin
                    eh = eq_h.pop_front();
                    ee = eq_e.pop_front();
                    chk("b2b hdr", pkts_hdr_out, eh);
                    chk("b2b err", HL'(out_err), HL'(ee));
                end
                if (last_t >= 0) chk("b2b period", HL'(t - last_t), HL'(NA + 2));
                last_t = t;
                got++;
            end
            adv = in_valid && in_ready;
            if (adv) begin
                model(bh[sent], ba[sent], b2[sent], b4[sent], b6[sent], eh, ee);
                eq_h.push_back(eh);
                eq_e.push_back(ee);
                sent++;
            end
            @(negedge clk);
            t++;
            if (adv) begin
                if (sent < 4) begin
                    pkts_hdr_in = bh[sent]; deparse_acts = ba[sent];
                    phv_2b = b2[sent]; phv_4b = b4[sent]; phv_6b = b6[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        chk("b2b count", HL'(got), HL'(4));

        // Random packets with random backpressure.
        for (int n = 0; n < 20; n++) begin
            rand_pkt(h, acts, p2, p4, p6);
            run_pkt("random", h, acts, p2, p4, p6, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
